// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int unsigned num_blocks(input int unsigned width,
                                               input int unsigned block_width);
        return width / block_width;
    endfunction

    function automatic bit width_ok(input int unsigned width,
                                    input int unsigned block_width);
        return (block_width != 0) && (width != 0) && ((width % block_width) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand and result streams of the pipelined adder, each with a valid/ready handshake.
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_carry;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_carry, in_mode, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_carry, in_mode, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_overflow
    );
endinterface

// File: rtl/cla_slice.sv
// One combinational carry-lookahead slice: sum bits, block propagate/generate and carry-out.
module cla_slice #(
    parameter int unsigned BLOCK_WIDTH = 8
) (
    input  logic [BLOCK_WIDTH-1:0] i_a,
    input  logic [BLOCK_WIDTH-1:0] i_b,
    input  logic                   i_cin,
    output logic [BLOCK_WIDTH-1:0] o_sum_c,
    output logic                   o_block_p_c,
    output logic                   o_block_g_c,
    output logic                   o_cout_c,
    output logic                   o_c_msb_c
);
    logic [BLOCK_WIDTH-1:0] w_g;
    logic [BLOCK_WIDTH-1:0] w_p;
    logic [BLOCK_WIDTH-1:0] w_c;
    logic                   w_gfold;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // w_c[i] is the carry into bit i; w_gfold folds generate from LSB upward
    always_comb begin
        w_c     = '0;
        w_c[0]  = i_cin;
        w_gfold = 1'b0;
        for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
            if (i + 1 < BLOCK_WIDTH) begin
                w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
            end
            w_gfold = w_g[i] | (w_p[i] & w_gfold);
        end
    end

    assign o_sum_c     = w_p ^ w_c;
    assign o_block_p_c = &w_p;
    assign o_block_g_c = w_gfold;
    assign o_cout_c    = w_gfold | (o_block_p_c & i_cin);
    assign o_c_msb_c   = w_c[BLOCK_WIDTH-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one lookahead slice per stage, block carry registered between stages.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BLOCK_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int unsigned NUM_BLOCKS = num_blocks(WIDTH, BLOCK_WIDTH);

    if (!width_ok(WIDTH, BLOCK_WIDTH)) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK_WIDTH");
    end

    // Rank 0 holds the conditioned input beat; rank k+1 holds the beat after slice k
    logic             r_valid [NUM_BLOCKS+1];
    logic [WIDTH-1:0] r_a     [NUM_BLOCKS+1];
    logic [WIDTH-1:0] r_b     [NUM_BLOCKS+1];
    logic [WIDTH-1:0] r_sum   [NUM_BLOCKS+1];
    logic             r_c     [NUM_BLOCKS+1];
    logic             r_ovf;

    logic                                   w_en;
    logic [NUM_BLOCKS-1:0][BLOCK_WIDTH-1:0] w_slice_sum;
    logic [NUM_BLOCKS-1:0][WIDTH-1:0]       w_sum_next;
    logic [NUM_BLOCKS-1:0]                  w_cout;
    logic [NUM_BLOCKS-1:0]                  w_c_msb;
    logic [NUM_BLOCKS-1:0]                  w_blk_p;
    logic [NUM_BLOCKS-1:0]                  w_blk_g;
    logic                                   w_unused_blk;

    assign w_en         = !r_valid[NUM_BLOCKS] || bus.out_ready;
    assign w_unused_blk = ^{w_blk_p, w_blk_g};

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
        cla_slice #(
            .BLOCK_WIDTH (BLOCK_WIDTH)
        ) u_slice (
            .i_a         (r_a[k][k*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .i_b         (r_b[k][k*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .i_cin       (r_c[k]),
            .o_sum_c     (w_slice_sum[k]),
            .o_block_p_c (w_blk_p[k]),
            .o_block_g_c (w_blk_g[k]),
            .o_cout_c    (w_cout[k]),
            .o_c_msb_c   (w_c_msb[k])
        );
        // Lower slices are already resolved in r_sum[k]; slice k and above are still zero
        assign w_sum_next[k] = r_sum[k] | (WIDTH'(w_slice_sum[k]) << (k * BLOCK_WIDTH));
    end

    // Global enable shifts every rank at once; data only loads alongside a valid beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= NUM_BLOCKS; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_c[k]     <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_valid[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_a[0] <= bus.in_a;
                r_b[0] <= (bus.in_mode == MODE_ADD) ? bus.in_b : ~bus.in_b;
                r_c[0] <= (bus.in_mode == MODE_SUB) ? 1'b1 : bus.in_carry;
            end
            for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
                r_valid[k+1] <= r_valid[k];
                if (r_valid[k]) begin
                    r_a[k+1]   <= r_a[k];
                    r_b[k+1]   <= r_b[k];
                    r_sum[k+1] <= w_sum_next[k];
                    r_c[k+1]   <= w_cout[k];
                end
            end
            if (r_valid[NUM_BLOCKS-1]) begin
                r_ovf <= w_c_msb[NUM_BLOCKS-1] ^ w_cout[NUM_BLOCKS-1];
            end
        end
    end

    assign bus.in_ready     = w_en;
    assign bus.out_valid    = r_valid[NUM_BLOCKS];
    assign bus.out_sum      = r_sum[NUM_BLOCKS];
    assign bus.out_carry    = r_c[NUM_BLOCKS];
    assign bus.out_overflow = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: a 32/8 four-stage unit and a 16/16 single-stage unit driven in lockstep.
module tb_pipelined_cla_adder;
    import adder_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    bit   rdy_mode;
    bit   lat_on;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb [2][$];
    exp_t drv_exp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_cla_adder_if #(.WIDTH(32)) if32 ();
    pipelined_cla_adder_if #(.WIDTH(16)) if16 ();

    pipelined_cla_adder #(.WIDTH(32), .BLOCK_WIDTH(8)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    pipelined_cla_adder #(.WIDTH(16), .BLOCK_WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    assign if32.out_ready = rdy;
    assign if16.out_ready = rdy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Reference: plain wide addition of conditioned operands, masked to w bits
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic mode);
        logic [32:0] full;
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] beff;
        logic        ci;
        exp_t        e;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am    = a & mask;
        beff  = ((mode == MODE_SUB) ? ~b : b) & mask;
        ci    = (mode == MODE_SUB) ? 1'b1 : cin;
        full  = {1'b0, am} + {1'b0, beff} + {32'd0, ci};
        e.sum   = full[31:0] & mask;
        e.carry = full[w];
        e.ovf   = (am[w-1] == beff[w-1]) && (full[w-1] != am[w-1]);
        e.acc   = 0;
        return e;
    endfunction

    task automatic scramble();
        if32.in_a = $urandom; if32.in_b = $urandom;
        if32.in_carry = 1'($urandom); if32.in_mode = 1'($urandom);
        if16.in_a = 16'($urandom); if16.in_b = 16'($urandom);
        if16.in_carry = 1'($urandom); if16.in_mode = 1'($urandom);
    endtask

    // Holds the beat on each unit until that unit accepts it
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic mode, input exp_t e32);
        logic [1:0] pend;
        logic [1:0] acc;
        int         guard;
        drv_exp[0] = e32;
        drv_exp[1] = model(16, a, b, cin, mode);
        if32.in_a = a;          if32.in_b = b;          if32.in_carry = cin; if32.in_mode = mode;
        if16.in_a = a[15:0];    if16.in_b = b[15:0];    if16.in_carry = cin; if16.in_mode = mode;
        pend = 2'b11;
        if32.in_valid = 1'b1;
        if16.in_valid = 1'b1;
        guard = 0;
        while (pend != 2'b00 && guard < 50) begin
            @(negedge clk);
            acc = pend & {if16.in_ready, if32.in_ready};
            @(posedge clk);
            #1;
            pend = pend & ~acc;
            if32.in_valid = pend[0];
            if16.in_valid = pend[1];
            guard++;
        end
        if (pend != 2'b00) check_val("send_timeout", 64'(pend), 64'd0);
        if32.in_valid = 1'b0;
        if16.in_valid = 1'b0;
        scramble();
    endtask

    task automatic send_rand();
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        mode;
        a = $urandom; b = $urandom; cin = 1'($urandom); mode = 1'($urandom);
        send(a, b, cin, mode, model(32, a, b, cin, mode));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            scramble();
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb[0].size() + sb[1].size()) != 0 && g < 60) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val("drain_left", 64'(sb[0].size() + sb[1].size()), 64'd0);
    endtask

    task automatic check_reset_state();
        check_val("rst_valid32", 64'(if32.out_valid), 64'd0);
        check_val("rst_sum32",   64'(if32.out_sum), 64'd0);
        check_val("rst_carry32", 64'(if32.out_carry), 64'd0);
        check_val("rst_ovf32",   64'(if32.out_overflow), 64'd0);
        check_val("rst_ready32", 64'(if32.in_ready), 64'd1);
        check_val("rst_valid16", 64'(if16.out_valid), 64'd0);
        check_val("rst_sum16",   64'(if16.out_sum), 64'd0);
        check_val("rst_carry16", 64'(if16.out_carry), 64'd0);
        check_val("rst_ovf16",   64'(if16.out_overflow), 64'd0);
        check_val("rst_ready16", 64'(if16.in_ready), 64'd1);
    endtask

    // Monitor: pushes accepted beats, pops and compares consumed results, checks stall behaviour
    logic [31:0] h_sum [2];
    logic        h_c   [2];
    logic        h_o   [2];
    logic        stall_q [2];
    always @(negedge clk) begin
        logic [31:0] osum [2];
        logic        ov [2], oc [2], oo [2], ir [2], iv [2];
        exp_t        e;
        osum[0] = if32.out_sum;        osum[1] = 32'(if16.out_sum);
        ov[0] = if32.out_valid;        ov[1] = if16.out_valid;
        oc[0] = if32.out_carry;        oc[1] = if16.out_carry;
        oo[0] = if32.out_overflow;     oo[1] = if16.out_overflow;
        ir[0] = if32.in_ready;         ir[1] = if16.in_ready;
        iv[0] = if32.in_valid;         iv[1] = if16.in_valid;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                stall_q[d] = 1'b0;
            end else begin
                if (iv[d] && ir[d]) begin
                    e = drv_exp[d];
                    e.acc = cyc + 1;
                    sb[d].push_back(e);
                end
                check_val($sformatf("in_ready_u%0d", d), 64'(ir[d]), 64'(!ov[d] || rdy));
                if (stall_q[d]) begin
                    check_val($sformatf("hold_valid_u%0d", d), 64'(ov[d]), 64'd1);
                    check_val($sformatf("hold_sum_u%0d", d), 64'(osum[d]), 64'(h_sum[d]));
                    check_val($sformatf("hold_carry_u%0d", d), 64'(oc[d]), 64'(h_c[d]));
                    check_val($sformatf("hold_ovf_u%0d", d), 64'(oo[d]), 64'(h_o[d]));
                end
                stall_q[d] = ov[d] && !rdy;
                h_sum[d] = osum[d];
                h_c[d]   = oc[d];
                h_o[d]   = oo[d];
                if (ov[d] && rdy) begin
                    if (sb[d].size() == 0) begin
                        check_val($sformatf("spurious_u%0d", d), 64'(ov[d]), 64'd0);
                    end else begin
                        e = sb[d].pop_front();
                        check_val($sformatf("sum_u%0d", d), 64'(osum[d]), 64'(e.sum));
                        check_val($sformatf("carry_u%0d", d), 64'(oc[d]), 64'(e.carry));
                        check_val($sformatf("ovf_u%0d", d), 64'(oo[d]), 64'(e.ovf));
                        if (lat_on) begin
                            check_val($sformatf("latency_u%0d", d), 64'(cyc - e.acc), 64'(nb(d)));
                        end
                    end
                end
            end
        end
    end

    // out_ready source: constant 1, or the repeating 1,0,0,1 pattern
    initial begin
        logic [3:0] pat;
        int         pc;
        pat = 4'b1001;
        pc  = 0;
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                rdy = pat[pc];
                pc  = (pc + 1) % 4;
            end else begin
                rdy = 1'b1;
            end
        end
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        rdy_mode = 1'b0;
        lat_on   = 1'b1;
        rst_n    = 1'b0;
        if32.in_valid = 1'b0;
        if16.in_valid = 1'b0;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state();

        // Full-width carry ripple, then subtraction borrow and signed overflow
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, '{32'h0000_0000, 1'b1, 1'b0, 0});
        drain();
        send(32'h0000_0005, 32'h0000_0007, 1'b0, MODE_SUB, '{32'hFFFF_FFFE, 1'b0, 1'b0, 0});
        send(32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, '{32'h7FFF_FFFF, 1'b1, 1'b1, 0});
        send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, MODE_ADD, '{32'h8000_0000, 1'b0, 1'b1, 0});
        drain();

        // Back-to-back mixed stream at full rate
        repeat (16) send_rand();
        drain();

        // Backpressure with toggling out_ready
        lat_on   = 1'b0;
        rdy_mode = 1'b1;
        repeat (6) send_rand();
        drain();
        rdy_mode = 1'b0;
        idle(2);
        lat_on = 1'b1;

        // Bubbles with garbage on idle operand lines
        repeat (3) begin
            send_rand();
            idle(1);
        end
        drain();

        // Reset with beats in flight: nothing stale may emerge afterwards
        repeat (3) send_rand();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb[0].delete();
        sb[1].delete();
        check_reset_state();
        idle(8);
        send_rand();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
